// File: rtl/rx_tap_sequencer_if.sv
// Tap stream from the receive-path sequencer to the matched-filter MAC.
// Valid/ready handshake; the sequencer side is the master.
interface rx_tap_sequencer_if #(
   parameter int unsigned WIDTH = 16
);
   logic [WIDTH-1:0] tap_data;
   logic [2:0]       tap_index;
   logic             tap_last;
   logic             tap_valid;
   logic             tap_ready;

   modport master (
      output tap_data,
      output tap_index,
      output tap_last,
      output tap_valid,
      input  tap_ready
   );

   modport slave (
      input  tap_data,
      input  tap_index,
      input  tap_last,
      input  tap_valid,
      output tap_ready
   );
endinterface

// File: rtl/rx_tap_sequencer.sv
// Turns each sample strobe into one shift-register shift followed by a sweep over taps 1..NTAPS.
// Define TAP_SEQ_PENDING_EN to queue one strobe that arrives mid-sweep instead of dropping it.
module rx_tap_sequencer #(
   parameter int unsigned NTAPS = 6,
   parameter int unsigned WIDTH = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                sample_strobe,
   output logic                sr_rxstrobe,
   output logic [2:0]          sr_sel,
   input  logic [WIDTH-1:0]    sr_data,
   rx_tap_sequencer_if.master  tap,
   output logic                busy,
   output logic                overrun,
   input  logic                overrun_clr
);

   localparam logic [2:0] LastTap = 3'(NTAPS);

   typedef enum logic [2:0] {StIdle, StStrobe, StSelect, StLoad, StPresent} state_e;

   state_e           state_q, state_d;
   logic [2:0]       k_q, k_d;
   logic [WIDTH-1:0] tap_data_q, tap_data_d;
   logic [2:0]       tap_index_q, tap_index_d;
   logic             tap_last_q, tap_last_d;
   logic             tap_valid_q, tap_valid_d;
   logic             overrun_q, overrun_d;
   logic             pending_q;
   logic             overrun_evt;
   logic             final_accept;

   assign final_accept = (state_q == StPresent) && tap.tap_ready && (k_q == LastTap);
   assign busy         = (state_q != StIdle);

`ifdef TAP_SEQ_PENDING_EN
   logic pending_d;
   logic pending_used;
   logic strobe_queued;

   always_comb begin
      pending_used  = pending_q && ((state_q == StIdle) || final_accept);
      // Only a strobe into a truly idle sequencer bypasses the pending slot.
      strobe_queued = sample_strobe && !((state_q == StIdle) && !pending_q);
      pending_d     = pending_q && !pending_used;
      overrun_evt   = 1'b0;
      if (strobe_queued) begin
         if (!pending_q || pending_used) begin
            pending_d = 1'b1;
         end else begin
            overrun_evt = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pending_q <= 1'b0;
      end else begin
         pending_q <= pending_d;
      end
   end
`else
   assign pending_q   = 1'b0;
   assign overrun_evt = sample_strobe && busy;
`endif

   // A new overrun wins over a coincident clear.
   always_comb begin
      overrun_d = overrun_q;
      if (overrun_evt) begin
         overrun_d = 1'b1;
      end else if (overrun_clr) begin
         overrun_d = 1'b0;
      end
   end

   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      tap_data_d  = tap_data_q;
      tap_index_d = tap_index_q;
      tap_last_d  = tap_last_q;
      tap_valid_d = tap_valid_q;
      sr_rxstrobe = 1'b0;
      sr_sel      = 3'd0;
      case (state_q)
         StIdle: begin
            if (sample_strobe || pending_q) begin
               state_d = StStrobe;
               k_d     = 3'd1;
            end
         end
         StStrobe: begin
            sr_rxstrobe = 1'b1;
            k_d         = 3'd1;
            state_d     = StSelect;
         end
         StSelect: begin
            sr_sel  = k_q;
            state_d = StLoad;
         end
         StLoad: begin
            sr_sel      = k_q;
            tap_data_d  = sr_data;
            tap_index_d = k_q;
            tap_last_d  = (k_q == LastTap);
            tap_valid_d = 1'b1;
            state_d     = StPresent;
         end
         StPresent: begin
            // Keep the select asserted so sr_data stays put while stalled.
            sr_sel = k_q;
            if (tap.tap_ready) begin
               tap_valid_d = 1'b0;
               if (k_q == LastTap) begin
                  k_d     = 3'd0;
                  state_d = pending_q ? StStrobe : StIdle;
               end else begin
                  k_d     = k_q + 3'd1;
                  state_d = StSelect;
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         k_q         <= 3'd0;
         tap_data_q  <= '0;
         tap_index_q <= 3'd0;
         tap_last_q  <= 1'b0;
         tap_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         tap_data_q  <= tap_data_d;
         tap_index_q <= tap_index_d;
         tap_last_q  <= tap_last_d;
         tap_valid_q <= tap_valid_d;
         overrun_q   <= overrun_d;
      end
   end

   assign tap.tap_data  = tap_data_q;
   assign tap.tap_index = tap_index_q;
   assign tap.tap_last  = tap_last_q;
   assign tap.tap_valid = tap_valid_q;
   assign overrun       = overrun_q;

endmodule

// File: tb/tb_rx_tap_sequencer.sv
// Directed bench for rx_tap_sequencer with a behavioural 6-deep shift register on the sr_* side.
// Expectations follow the TAP_SEQ_PENDING_EN setting used for the build.
module tb_rx_tap_sequencer;
   localparam int unsigned NTAPS = 6;
   localparam int unsigned WIDTH = 16;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             sample_strobe = 1'b0;
   logic             overrun_clr = 1'b0;
   logic             sr_rxstrobe;
   logic [2:0]       sr_sel;
   logic [WIDTH-1:0] sr_data = '0;
   logic             busy;
   logic             overrun;

   logic [WIDTH-1:0] sr_taps [NTAPS];
   logic [WIDTH-1:0] in_sample = '0;
   logic             sr_preload = 1'b0;

   int checks = 0;
   int errors = 0;

   rx_tap_sequencer_if #(.WIDTH(WIDTH)) tap_if ();

   rx_tap_sequencer #(.NTAPS(NTAPS), .WIDTH(WIDTH)) dut (
      .clk          (clk),
      .reset        (reset),
      .sample_strobe(sample_strobe),
      .sr_rxstrobe  (sr_rxstrobe),
      .sr_sel       (sr_sel),
      .sr_data      (sr_data),
      .tap          (tap_if),
      .busy         (busy),
      .overrun      (overrun),
      .overrun_clr  (overrun_clr)
   );

   always #5 clk = ~clk;

   // Shift register model: shift has priority over the registered tap read.
   always @(posedge clk) begin
      if (sr_preload) begin
         for (int i = 0; i < NTAPS; i++) sr_taps[i] <= 16'(i + 1) * 16'h0101;
      end else if (sr_rxstrobe) begin
         for (int i = NTAPS - 1; i > 0; i--) sr_taps[i] <= sr_taps[i - 1];
         sr_taps[0] <= in_sample;
      end else if (sr_sel != 3'd0 && int'(sr_sel) <= NTAPS) begin
         sr_data <= sr_taps[int'(sr_sel) - 1];
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string name);
      bit done;
      done = 1'b0;
      for (int n = 0; n < 100 && !done; n++) begin
         if (!busy) done = 1'b1;
         else step();
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL %s_idle: busy=%b after 100 cycles, want 0", name, busy);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({sr_rxstrobe, sr_sel, busy, overrun} !== 6'd0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b want 000000", {sr_rxstrobe, sr_sel, busy, overrun});
      end
      checks++;
      if ({tap_if.tap_valid, tap_if.tap_data, tap_if.tap_index, tap_if.tap_last} !== 21'd0) begin
         errors++;
         $display("FAIL reset_stream: got %h want 0",
                  {tap_if.tap_valid, tap_if.tap_data, tap_if.tap_index, tap_if.tap_last});
      end
      reset = 1'b1;
      tap_if.tap_ready = 1'b1;
      sr_preload = 1'b1;
      step();
      sr_preload = 1'b0;
   endtask

   task automatic test_sweep();
      logic [WIDTH-1:0] exp_data [6];
      exp_data = '{16'hAAAA, 16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505};
      in_sample = 16'hAAAA;
      sample_strobe = 1'b1;
      step();
      sample_strobe = 1'b0;
      for (int c = 1; c <= 21; c++) begin
         bit v;
         int idx;
         v = (c >= 4 && c <= 19 && (c % 3) == 1);
         idx = (c - 1) / 3;
         checks++;
         if (sr_rxstrobe !== (c == 1)) begin
            errors++;
            $display("FAIL sweep_rxstrobe c=%0d: got %b want %b", c, sr_rxstrobe, c == 1);
         end
         checks++;
         if (tap_if.tap_valid !== v) begin
            errors++;
            $display("FAIL sweep_valid c=%0d: got %b want %b", c, tap_if.tap_valid, v);
         end
         if (v) begin
            checks++;
            if ({tap_if.tap_data, tap_if.tap_index, tap_if.tap_last} !==
                {exp_data[idx - 1], 3'(idx), idx == 6}) begin
               errors++;
               $display("FAIL sweep_tap c=%0d: got %h/%0d/%b want %h/%0d/%b", c,
                        tap_if.tap_data, tap_if.tap_index, tap_if.tap_last,
                        exp_data[idx - 1], idx, idx == 6);
            end
         end
         checks++;
         if (busy !== (c < 20)) begin
            errors++;
            $display("FAIL sweep_busy c=%0d: got %b want %b", c, busy, c < 20);
         end
         if (c == 2) begin
            checks++;
            if (sr_sel !== 3'd1) begin
               errors++;
               $display("FAIL sweep_sel c=2: got %0d want 1", sr_sel);
            end
         end
         step();
      end
   endtask

   task automatic test_backpressure();
      logic [WIDTH-1:0] exp_data [6];
      bit found;
      int nxt;
      exp_data = '{16'hBBBB, 16'hAAAA, 16'h0101, 16'h0202, 16'h0303, 16'h0404};
      in_sample = 16'hBBBB;
      sample_strobe = 1'b1;
      step();
      sample_strobe = 1'b0;
      found = 1'b0;
      for (int n = 0; n < 40 && !found; n++) begin
         if (tap_if.tap_valid && tap_if.tap_index == 3'd3) found = 1'b1;
         else step();
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL bp_reach_tap3: got found=0 want 1");
      end
      tap_if.tap_ready = 1'b0;
      for (int s = 0; s < 10; s++) begin
         step();
         checks++;
         if ({tap_if.tap_valid, tap_if.tap_data, tap_if.tap_index, sr_rxstrobe} !==
             {1'b1, exp_data[2], 3'd3, 1'b0}) begin
            errors++;
            $display("FAIL bp_hold s=%0d: got v=%b d=%h i=%0d rx=%b want v=1 d=%h i=3 rx=0", s,
                     tap_if.tap_valid, tap_if.tap_data, tap_if.tap_index, sr_rxstrobe,
                     exp_data[2]);
         end
      end
      tap_if.tap_ready = 1'b1;
      nxt = 3;
      for (int n = 0; n < 40 && nxt <= 6; n++) begin
         if (tap_if.tap_valid) begin
            checks++;
            if ({tap_if.tap_data, tap_if.tap_index} !== {exp_data[nxt - 1], 3'(nxt)}) begin
               errors++;
               $display("FAIL bp_order: got %h/%0d want %h/%0d", tap_if.tap_data,
                        tap_if.tap_index, exp_data[nxt - 1], nxt);
            end
            nxt++;
         end
         step();
      end
      checks++;
      if (nxt != 7) begin
         errors++;
         $display("FAIL bp_count: got next=%0d want 7", nxt);
      end
      wait_idle("bp");
   endtask

   task automatic test_strobe_while_busy();
      logic [WIDTH-1:0] exp1 [6];
      logic [WIDTH-1:0] exp2 [6];
      exp1 = '{16'hCCCC, 16'hBBBB, 16'hAAAA, 16'h0101, 16'h0202, 16'h0303};
      exp2 = '{16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA, 16'h0101, 16'h0202};
      in_sample = 16'hCCCC;
      sample_strobe = 1'b1;
      step();
      sample_strobe = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         bit rx_e, v, busy_e, ovr_e;
         int idx;
         logic [WIDTH-1:0] d_e;
         v = (c >= 4 && c <= 19 && (c % 3) == 1);
         idx = (c - 1) / 3;
         d_e = v ? exp1[idx - 1] : '0;
`ifdef TAP_SEQ_PENDING_EN
         rx_e = (c == 1 || c == 20);
         busy_e = (c <= 38);
         ovr_e = 1'b0;
         if (c >= 23 && c <= 38 && (c % 3) == 2) begin
            v = 1'b1;
            idx = (c - 20) / 3;
            d_e = exp2[idx - 1];
         end
`else
         rx_e = (c == 1);
         busy_e = (c < 20);
         ovr_e = (c >= 9);
`endif
         checks++;
         if ({sr_rxstrobe, tap_if.tap_valid, busy, overrun} !== {rx_e, v, busy_e, ovr_e}) begin
            errors++;
            $display("FAIL busy_ctrl c=%0d: got rx/v/busy/ovr=%b want %b", c,
                     {sr_rxstrobe, tap_if.tap_valid, busy, overrun}, {rx_e, v, busy_e, ovr_e});
         end
         if (v) begin
            checks++;
            if ({tap_if.tap_data, tap_if.tap_index} !== {d_e, 3'(idx)}) begin
               errors++;
               $display("FAIL busy_tap c=%0d: got %h/%0d want %h/%0d", c, tap_if.tap_data,
                        tap_if.tap_index, d_e, idx);
            end
         end
         sample_strobe = (c == 8);
         if (c == 8) in_sample = 16'hDDDD;
         step();
      end
      sample_strobe = 1'b0;
      wait_idle("busy");
   endtask

   task automatic test_overrun();
      int ov_start;
`ifdef TAP_SEQ_PENDING_EN
      ov_start = 11;
`else
      ov_start = 9;
`endif
      overrun_clr = 1'b1;
      step();
      overrun_clr = 1'b0;
      in_sample = 16'h1111;
      sample_strobe = 1'b1;
      step();
      sample_strobe = 1'b0;
      for (int c = 1; c <= 16; c++) begin
         bit e;
         e = (c >= ov_start && c < 13) || (c >= 15);
         checks++;
         if (overrun !== e) begin
            errors++;
            $display("FAIL overrun c=%0d: got %b want %b", c, overrun, e);
         end
         sample_strobe = (c == 8 || c == 10 || c == 14);
         overrun_clr = (c == 12 || c == 14);
         step();
      end
      sample_strobe = 1'b0;
      overrun_clr = 1'b0;
      wait_idle("ovr");
      overrun_clr = 1'b1;
      step();
      overrun_clr = 1'b0;
      checks++;
      if (overrun !== 1'b0) begin
         errors++;
         $display("FAIL overrun_final_clr: got %b want 0", overrun);
      end
   endtask

   task automatic test_reset_mid_sweep();
      in_sample = 16'h1234;
      sample_strobe = 1'b1;
      step();
      sample_strobe = 1'b0;
      repeat (12) step();
      checks++;
      if ({tap_if.tap_valid, tap_if.tap_index} !== {1'b1, 3'd4}) begin
         errors++;
         $display("FAIL rst_pre: got v=%b i=%0d want v=1 i=4", tap_if.tap_valid, tap_if.tap_index);
      end
      tap_if.tap_ready = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if ({sr_rxstrobe, sr_sel, busy, overrun} !== 6'd0) begin
         errors++;
         $display("FAIL rst_async_ctrl: got %b want 000000", {sr_rxstrobe, sr_sel, busy, overrun});
      end
      checks++;
      if ({tap_if.tap_valid, tap_if.tap_data, tap_if.tap_index, tap_if.tap_last} !== 21'd0) begin
         errors++;
         $display("FAIL rst_async_stream: got %h want 0",
                  {tap_if.tap_valid, tap_if.tap_data, tap_if.tap_index, tap_if.tap_last});
      end
      step();
      step();
      reset = 1'b1;
      tap_if.tap_ready = 1'b1;
      step();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL rst_no_resume: got busy=%b want 0", busy);
      end
      in_sample = 16'h5678;
      sample_strobe = 1'b1;
      step();
      sample_strobe = 1'b0;
      checks++;
      if (sr_rxstrobe !== 1'b1) begin
         errors++;
         $display("FAIL rst_restart_rx: got %b want 1", sr_rxstrobe);
      end
      repeat (3) step();
      checks++;
      if ({tap_if.tap_valid, tap_if.tap_index, tap_if.tap_data} !== {1'b1, 3'd1, 16'h5678}) begin
         errors++;
         $display("FAIL rst_restart_tap: got v=%b i=%0d d=%h want v=1 i=1 d=5678",
                  tap_if.tap_valid, tap_if.tap_index, tap_if.tap_data);
      end
      wait_idle("rst");
   endtask

   initial begin
      tap_if.tap_ready = 1'b1;
      test_reset();
      test_sweep();
      test_backpressure();
      test_strobe_while_busy();
      test_overrun();
      test_reset_mid_sweep();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
